// File: rtl/stage_2_inverse_permutation.sv
// rtl/stage_2_inverse_permutation.sv - inverse stage-2 lane shuffle, 2-cycle pipeline with frame sideband
// Optional frame-restart checker: define STAGE2_INVPERM_FRAME_CHK_EN to add errRestart.
module stage_2_inverse_permutation #(
    parameter int DATA_WIDTH_PER_INPUT = 32,
    parameter int INPUT_PER_CYCLE      = 32,
    parameter int FRAME_CYCLES         = 32,
    parameter int SWAP_BIT_LO          = 0,
    parameter int SWAP_BIT_HI          = 3
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            inStart,
    input  logic [INPUT_PER_CYCLE*DATA_WIDTH_PER_INPUT-1:0] inData,
    output logic                                            outStart,
    output logic                                            outValid,
    output logic                                            outLast,
    output logic [INPUT_PER_CYCLE*DATA_WIDTH_PER_INPUT-1:0] outData
`ifdef STAGE2_INVPERM_FRAME_CHK_EN
    ,
    output logic                                            errRestart
`endif
);

    localparam int W     = DATA_WIDTH_PER_INPUT;
    localparam int BUS_W = INPUT_PER_CYCLE * DATA_WIDTH_PER_INPUT;
    localparam int CNT_W = $clog2(FRAME_CYCLES) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_CYCLES - 1);

    localparam logic IDLE = 1'b0;
    localparam logic RUN  = 1'b1;

    logic             state, nextState;
    logic [CNT_W-1:0] cnt, nextCnt;
    logic             tagStart, tagValid, tagLast;

    logic [BUS_W-1:0] s1Data;
    logic             s1Start, s1Valid, s1Last;
    logic [BUS_W-1:0] permData;

    // Frame tagging happens on the input beat; the tags then ride the pipeline with the data.
    always_comb begin
        nextState = state;
        nextCnt   = cnt;
        tagStart  = 1'b0;
        tagValid  = 1'b0;
        tagLast   = 1'b0;
        if (inStart) begin
            tagStart = 1'b1;
            tagValid = 1'b1;
            if (FRAME_CYCLES == 1) begin
                tagLast   = 1'b1;
                nextState = IDLE;
                nextCnt   = '0;
            end else begin
                nextState = RUN;
                nextCnt   = CNT_W'(1);
            end
        end else if (state == RUN) begin
            tagValid = 1'b1;
            if (cnt == LAST_CNT) begin
                tagLast   = 1'b1;
                nextState = IDLE;
                nextCnt   = '0;
            end else begin
                nextCnt = cnt + 1'b1;
            end
        end
    end

    // Output lane j takes input lane j with the two swap bits exchanged.
    for (genvar j = 0; j < INPUT_PER_CYCLE; j++) begin : gLane
        localparam int BLO = (j >> SWAP_BIT_LO) & 1;
        localparam int BHI = (j >> SWAP_BIT_HI) & 1;
        localparam int SRC = (j & ~((1 << SWAP_BIT_LO) | (1 << SWAP_BIT_HI)))
                           | (BLO << SWAP_BIT_HI) | (BHI << SWAP_BIT_LO);
        assign permData[j*W +: W] = s1Data[SRC*W +: W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            s1Data   <= '0;
            s1Start  <= 1'b0;
            s1Valid  <= 1'b0;
            s1Last   <= 1'b0;
            outData  <= '0;
            outStart <= 1'b0;
            outValid <= 1'b0;
            outLast  <= 1'b0;
        end else begin
            state    <= nextState;
            cnt      <= nextCnt;
            s1Data   <= inData;
            s1Start  <= tagStart;
            s1Valid  <= tagValid;
            s1Last   <= tagLast;
            outData  <= permData;
            outStart <= s1Start;
            outValid <= s1Valid;
            outLast  <= s1Last;
        end
    end

`ifdef STAGE2_INVPERM_FRAME_CHK_EN
    logic s1Err;

    // Sticky; lands on the same cycle as the outStart of the restarting beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1Err      <= 1'b0;
            errRestart <= 1'b0;
        end else begin
            s1Err      <= inStart && (state == RUN);
            errRestart <= errRestart | s1Err;
        end
    end
`endif

endmodule

// File: tb/tb_stage_2_inverse_permutation.sv
// tb/tb_stage_2_inverse_permutation.sv - self-checking bench for stage_2_inverse_permutation
module tb_stage_2_inverse_permutation;

    localparam int NCYC = 72;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          inStart = 1'b0;
    logic [1023:0] inData = '0;
    logic          outStart, outValid, outLast;
    logic [1023:0] outData;
`ifdef STAGE2_INVPERM_FRAME_CHK_EN
    logic          errRestart;
`endif

    stage_2_inverse_permutation dut (
        .clk(clk),
        .rst(rst),
        .inStart(inStart),
        .inData(inData),
        .outStart(outStart),
        .outValid(outValid),
        .outLast(outLast),
        .outData(outData)
`ifdef STAGE2_INVPERM_FRAME_CHK_EN
        ,
        .errRestart(errRestart)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string nm;
        int    scen;
        int    cyc;
        bit    s;
        bit    v;
        bit    l;
    } vec_t;

    int checks = 0;
    int passes = 0;

    logic          logS [0:3][0:NCYC-1];
    logic          logV [0:3][0:NCYC-1];
    logic          logL [0:3][0:NCYC-1];
    logic          logE [0:3][0:NCYC-1];
    logic [1023:0] expOut [0:NCYC-1];
    logic [1023:0] data20;

    function automatic logic [1023:0] swapLanes(input logic [1023:0] d);
        logic [1023:0] r;
        for (int k = 0; k < 32; k++) begin
            logic [4:0] kk;
            logic [4:0] src;
            kk  = k[4:0];
            src = {kk[4], kk[0], kk[2], kk[1], kk[3]};
            r[k*32 +: 32] = d[src*32 +: 32];
        end
        return r;
    endfunction

    function automatic logic [1023:0] pattern(input int b);
        logic [1023:0] r;
        for (int k = 0; k < 32; k++) r[k*32 +: 32] = {b[15:0], k[15:0]};
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic chkData(input string nm, input int c, input logic [1023:0] act, input logic [1023:0] exp);
        checks++;
        if (act === exp) passes++;
        else begin
            for (int k = 0; k < 32; k++) begin
                if (act[k*32 +: 32] !== exp[k*32 +: 32]) begin
                    $display("FAIL %s cycle %0d lane %0d: got %h expected %h",
                             nm, c, k, act[k*32 +: 32], exp[k*32 +: 32]);
                    break;
                end
            end
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            inStart = 1'b1;
            for (int k = 0; k < 32; k++) inData[k*32 +: 32] = $urandom;
            @(negedge clk);
            if (i > 0) begin
                chk("rst_outStart", 32'(outStart), 0);
                chk("rst_outValid", 32'(outValid), 0);
                chk("rst_outLast", 32'(outLast), 0);
                chkData("rst_outData", i, outData, '0);
`ifdef STAGE2_INVPERM_FRAME_CHK_EN
                chk("rst_errRestart", 32'(errRestart), 0);
`endif
            end
            @(posedge clk); #1;
        end
        rst = 1'b0;
        inStart = 1'b0;
        @(negedge clk);
        chk("post_rst_outValid", 32'(outValid), 0);
        @(posedge clk); #1;
    endtask

    // mode 0: {beat,lane} pattern, expect permuted; mode 1: forward-shuffled natural data, expect natural.
    task automatic runScen(input int scen, input int s0, input int s1, input int rstAt, input int mode);
        doReset();
        for (int c = 0; c < NCYC; c++) begin
            rst     = (c == rstAt);
            inStart = (c == s0) || (c == s1);
            if (mode == 0) begin
                inData    = pattern(c - s0);
                expOut[c] = swapLanes(inData);
            end else begin
                expOut[c] = pattern(c);
                inData    = swapLanes(expOut[c]);
            end
            @(negedge clk);
            logS[scen][c] = outStart;
            logV[scen][c] = outValid;
            logL[scen][c] = outLast;
`ifdef STAGE2_INVPERM_FRAME_CHK_EN
            logE[scen][c] = errRestart;
`else
            logE[scen][c] = 1'b0;
`endif
            if (scen == 0 && c == 20) data20 = outData;
            if ((scen <= 1) && c >= 2 && outValid === 1'b1)
                chkData(mode == 0 ? "perm_data" : "involution_data", c, outData, expOut[c-2]);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        inStart = 1'b0;
    endtask

    initial begin
        vec_t vecs[$];
        vecs = '{
            '{"single_pre",    0, 11, 0, 0, 0},
            '{"single_start",  0, 12, 1, 1, 0},
            '{"single_beat1",  0, 13, 0, 1, 0},
            '{"single_beat30", 0, 42, 0, 1, 0},
            '{"single_last",   0, 43, 0, 1, 1},
            '{"single_after",  0, 44, 0, 0, 0},
            '{"b2b_pre",       1,  1, 0, 0, 0},
            '{"b2b_start0",    1,  2, 1, 1, 0},
            '{"b2b_last0",     1, 33, 0, 1, 1},
            '{"b2b_start1",    1, 34, 1, 1, 0},
            '{"b2b_last1",     1, 65, 0, 1, 1},
            '{"b2b_after",     1, 66, 0, 0, 0},
            '{"rs_start0",     2,  2, 1, 1, 0},
            '{"rs_beat19",     2, 21, 0, 1, 0},
            '{"rs_start1",     2, 22, 1, 1, 0},
            '{"rs_nolast33",   2, 33, 0, 1, 0},
            '{"rs_last",       2, 53, 0, 1, 1},
            '{"rs_after",      2, 54, 0, 0, 0},
            '{"mr_inflight",   3, 15, 0, 1, 0},
            '{"mr_flush16",    3, 16, 0, 0, 0},
            '{"mr_flush17",    3, 17, 0, 0, 0},
            '{"mr_idle21",     3, 21, 0, 0, 0},
            '{"mr_start",      3, 22, 1, 1, 0},
            '{"mr_beat1",      3, 23, 0, 1, 0}
        };

        runScen(0, 10, -1, -1, 0);
        runScen(1, 0, 32, -1, 1);
        runScen(2, 0, 20, -1, 0);
        runScen(3, 0, 20, 15, 0);

        foreach (vecs[i]) begin
            chk({vecs[i].nm, "_outStart"}, 32'(logS[vecs[i].scen][vecs[i].cyc]), 32'(vecs[i].s));
            chk({vecs[i].nm, "_outValid"}, 32'(logV[vecs[i].scen][vecs[i].cyc]), 32'(vecs[i].v));
            chk({vecs[i].nm, "_outLast"},  32'(logL[vecs[i].scen][vecs[i].cyc]), 32'(vecs[i].l));
        end

        chk("lane1_beat8",  data20[1*32 +: 32],  {16'd8, 16'd8});
        chk("lane8_beat8",  data20[8*32 +: 32],  {16'd8, 16'd1});
        chk("lane26_beat8", data20[26*32 +: 32], {16'd8, 16'd19});
        chk("lane0_beat8",  data20[0*32 +: 32],  {16'd8, 16'd0});

        for (int c = 2; c <= 65; c++) begin
            if (logV[1][c] !== 1'b1) chk($sformatf("b2b_continuous_c%0d", c), 32'(logV[1][c]), 1);
        end
        chk("b2b_continuous_all", 32'(logV[1][2:65] == '{default: 1'b1}), 1);
        for (int c = 16; c <= 21; c++) chk($sformatf("mr_nolast_c%0d", c), 32'(logL[3][c]), 0);
        for (int c = 16; c <= 21; c++) chk($sformatf("mr_novalid_c%0d", c), 32'(logV[3][c]), 0);

`ifdef STAGE2_INVPERM_FRAME_CHK_EN
        chk("err_before", 32'(logE[2][21]), 0);
        chk("err_rise",   32'(logE[2][22]), 1);
        chk("err_sticky", 32'(logE[2][70]), 1);
        chk("err_none_single", 32'(logE[0][60]), 0);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/stage_2_inverse_permutation.md
Name: stage_2_inverse_permutation

Overview:
- Output-side counterpart of the forward stage-2 lane shuffle. Used on the inverse-NTT path (N=1024, 32 coefficients/cycle) to restore natural lane order before the next butterfly stage.
- Undoes the lane shuffle as a 2-cycle registered pipeline.
- Tracks 32-beat frames from inStart. Regenerates aligned outStart, outValid and outLast so downstream stages need no counters of their own.

Parameters:
- DATA_WIDTH_PER_INPUT, 32, bits per coefficient.
- INPUT_PER_CYCLE, 32, lanes per beat (power of 2, ≥16).
- FRAME_CYCLES, 32, beats per frame (N / INPUT_PER_CYCLE).
- SWAP_BIT_LO, 0, lower lane-index bit exchanged.
- SWAP_BIT_HI, 3, upper lane-index bit exchanged (must be < log2(INPUT_PER_CYCLE)).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- inStart  in  1  pulse on the first beat of a frame.
- inData  in  INPUT_PER_CYCLE*DATA_WIDTH_PER_INPUT  lane k at bits [k*W +: W].
- outStart  out  1  pulse aligned with the first output beat.
- outValid  out  1  high on every output beat of an active frame.
- outLast  out  1  pulse aligned with the final beat (beat FRAME_CYCLES-1).
- outData  out  INPUT_PER_CYCLE*DATA_WIDTH_PER_INPUT  permuted lanes, same packing as inData.
- errRestart  out  1  sticky flag; exists only with the optional feature.

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. During rst, all output registers, both pipeline stages, the beat counter and the FSM clear to 0 / IDLE. outData=0, outStart=0, outValid=0, outLast=0, errRestart=0.
- Lane map: define p(j) as j with bits SWAP_BIT_LO and SWAP_BIT_HI exchanged. Output lane j = input lane p(j) of the same beat. With defaults: out1←in8, out8←in1, out3←in10, out0←in0, out15←in15, out17←in24. p is an involution.
- Pipeline:
  - Stage 1 registers raw inData plus the start/valid/last sideband.
  - Stage 2 registers the permuted data plus the sideband.
  - Latency is exactly 2 cycles for data and all sideband signals. Data is captured every cycle, including when idle; outData is only meaningful while outValid=1.
- FSM (evaluated at the input side, stage 0):
  - IDLE: on inStart=1, go to RUN with cnt=1. That beat is tagged start=1, valid=1, last=(FRAME_CYCLES==1).
  - RUN, inStart=0: each cycle tag valid=1 and cnt++. When cnt==FRAME_CYCLES-1, tag last=1 and return to IDLE with cnt=0.
  - RUN, inStart=1 (restart): the current beat is treated as beat 0 of a new frame (start=1, cnt=1). The old frame is abandoned without a last tag.
  - inStart=1 on the same cycle as the last beat of the current frame: that beat is a restart (start=1, not last). A new frame begins and no last is emitted for the old frame.
  - Back-to-back frames: inStart on the cycle after a last beat produces a continuous outValid with no gap.
- Counter width is clog2(FRAME_CYCLES)+1. No wrap beyond FRAME_CYCLES-1 is possible.
- Reset mid-frame: the pipeline flushes. Beats already in flight are discarded: outValid=0 on the first cycle after rst deasserts and stays 0 until a new inStart.
- inStart while rst=1 is ignored.

Optional Feature:
- Macro: STAGE2_INVPERM_FRAME_CHK_EN.
- Defined:
  - errRestart port is present.
  - It sets (registered, aligned with the offending outStart) when inStart arrives while the FSM is in RUN.
  - It stays set until rst.
- Undefined: errRestart port and its logic are absent. Restart behaviour is otherwise identical.

Test Plan:
- Reset: hold rst 3 cycles with random inData and inStart=1 → all outputs 0 throughout, and outValid=0 on the cycle after release.
- Single frame: inStart at cycle 10; lane k of beat b = {b[15:0], k[15:0]} for 32 beats →
  - outStart at cycle 12.
  - outValid cycles 12–43.
  - outLast at cycle 43.
  - On every beat, out lane 1 = {b,8}, lane 8 = {b,1}, lane 26 = {b,19}, lane 0 = {b,0}.
- Involution check: feed the output of the forward stage-2 shuffle model into the DUT → outData equals the original natural-order data on all 32 beats.
- Back-to-back frames: inStart at cycles 0 and 32 → outValid continuously high for cycles 2–65; outLast at 33 and 65; outStart at 2 and 34.
- Restart: inStart at cycle 0 and cycle 20 →
  - outStart at 2 and 22.
  - No outLast at 33; outLast at 53.
  - With STAGE2_INVPERM_FRAME_CHK_EN: errRestart rises at 22 and stays high.
- Reset mid-frame: inStart at 0, rst at cycle 15 for 1 cycle → outValid=0 from cycle 16 onward with no outLast. A following inStart at 20 gives outStart at 22.
